// File: rtl/tdes_pkg.sv
// Shared types and constants for the TDES CBC front-end and its chain register.
package tdes_pkg;

  localparam int unsigned BLOCK_W = 64;
  localparam int unsigned KEY_W   = 64;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Request presented to the tdes core; held stable until the next accept.
  typedef struct packed {
    logic               mode;
    logic [0:KEY_W-1]   key1;
    logic [0:KEY_W-1]   key2;
    logic [0:KEY_W-1]   key3;
    logic [0:BLOCK_W-1] data;
  } core_req_t;

endpackage

// File: rtl/cbc_chain_reg.sv
// CBC chain value and saved ciphertext, with the IV select and the XOR muxing
// applied on issue (encrypt) and on result (decrypt).
module cbc_chain_reg
  import tdes_pkg::*;
#(
  parameter bit CBC_EN = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               take_i,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic [0:BLOCK_W-1] iv_i,
  input  logic [0:BLOCK_W-1] data_i,
  input  logic               result_i,
  input  logic               mode_q_i,
  input  logic [0:BLOCK_W-1] core_data_i,
  output logic [0:BLOCK_W-1] issue_data_c,
  output logic [0:BLOCK_W-1] result_data_c
);

  logic [0:BLOCK_W-1] chain_q;
  logic [0:BLOCK_W-1] saved_ct_q;
  logic [0:BLOCK_W-1] chain_sel;

  // ECB forces a zero XOR operand, so start_i and iv_i have no effect.
  always_comb begin
    chain_sel     = '0;
    issue_data_c  = data_i;
    result_data_c = core_data_i;
    if (CBC_EN) begin
      chain_sel = start_i ? iv_i : chain_q;
      if (mode_i == MODE_ENC) begin
        issue_data_c = data_i ^ chain_sel;
      end
      if (mode_q_i == MODE_DEC) begin
        result_data_c = core_data_i ^ chain_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      chain_q    <= '0;
      saved_ct_q <= '0;
    end else if (CBC_EN) begin
      if (take_i) begin
        chain_q <= chain_sel;
        if (mode_i == MODE_DEC) begin
          saved_ct_q <= data_i;
        end
      end else if (result_i) begin
        chain_q <= (mode_q_i == MODE_ENC) ? core_data_i : saved_ct_q;
      end
    end
  end

endmodule

// File: rtl/tdes_cbc_ctrl.sv
// CBC chaining front-end between the host block stream and the tdes core;
// one block in flight, result held until the consumer takes it.
module tdes_cbc_ctrl
  import tdes_pkg::*;
#(
  parameter bit CBC_EN = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               mode_i,
  input  logic               start_i,
  input  logic [0:BLOCK_W-1] iv_i,
  input  logic [0:KEY_W-1]   key1_i,
  input  logic [0:KEY_W-1]   key2_i,
  input  logic [0:KEY_W-1]   key3_i,
  input  logic [0:BLOCK_W-1] data_i,
  input  logic               valid_i,
  output logic               accept_o,
  output logic [0:BLOCK_W-1] data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               core_mode_o,
  output logic [0:KEY_W-1]   core_key1_o,
  output logic [0:KEY_W-1]   core_key2_o,
  output logic [0:KEY_W-1]   core_key3_o,
  output logic [0:BLOCK_W-1] core_data_o,
  output logic               core_valid_o,
  input  logic               core_ready_i,
  input  logic [0:BLOCK_W-1] core_data_i,
  input  logic               core_valid_i,
  output logic               err_o
);

  state_t             state_q;
  core_req_t          req_q;
  logic               take;
  logic               chain_result;
  logic [0:BLOCK_W-1] issue_data_c;
  logic [0:BLOCK_W-1] result_data_c;

  assign accept_o     = (state_q == ST_IDLE) && core_ready_i;
  assign take         = valid_i && accept_o;
  assign chain_result = (state_q == ST_WAIT) && core_valid_i;

  assign core_mode_o = req_q.mode;
  assign core_key1_o = req_q.key1;
  assign core_key2_o = req_q.key2;
  assign core_key3_o = req_q.key3;
  assign core_data_o = req_q.data;

  cbc_chain_reg #(
    .CBC_EN(CBC_EN)
  ) u_chain (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .take_i        (take),
    .start_i       (start_i),
    .mode_i        (mode_i),
    .iv_i          (iv_i),
    .data_i        (data_i),
    .result_i      (chain_result),
    .mode_q_i      (req_q.mode),
    .core_data_i   (core_data_i),
    .issue_data_c  (issue_data_c),
    .result_data_c (result_data_c)
  );

  // core_valid_o is raised on the accept edge so it is high for exactly the ISSUE cycle.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      core_valid_o <= 1'b0;
      data_o       <= '0;
      valid_o      <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      core_valid_o <= 1'b0;
      if (core_valid_i && (state_q != ST_WAIT)) begin
        err_o <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (take) begin
            req_q.mode   <= mode_i;
            req_q.key1   <= key1_i;
            req_q.key2   <= key2_i;
            req_q.key3   <= key3_i;
            req_q.data   <= issue_data_c;
            core_valid_o <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_valid_i) begin
            data_o  <= result_data_c;
            valid_o <= 1'b1;
            state_q <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdes_cbc_ctrl.sv
// Bench for tdes_cbc_ctrl: a behavioural TDES core sits behind a CBC and an ECB
// instance; results are checked against known DES/CBC vectors via a queue.
module tb_tdes_cbc_ctrl;

  localparam int CORE_LAT = 3;
  localparam logic [63:0] KEY = 64'h0123456789abcdef;
  localparam logic [63:0] IV  = 64'h1234567890abcdef;

  int ip_t [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int fp_t [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                    34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  int e_t [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int p_t [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                    2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  int pc1_t [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                     19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int sh_t [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int sb_t [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  // Single DES, bit 1 of every table = MSB.
  function automatic logic [63:0] des(input logic [63:0] key, input logic [63:0] blk,
                                      input logic dec);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [47:0] e;
    logic [63:0] t, res;
    logic [31:0] l, r, f, sout, nl;
    logic [5:0]  six;
    int          row, col;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-pc1_t[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int rd = 0; rd < 16; rd++) begin
      for (int s = 0; s < sh_t[rd]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[rd][47-i] = cd[56-pc2_t[i]];
    end
    for (int i = 0; i < 64; i++) t[63-i] = blk[64-ip_t[i]];
    l = t[63:32];
    r = t[31:0];
    for (int rd = 0; rd < 16; rd++) begin
      for (int i = 0; i < 48; i++) e[47-i] = r[32-e_t[i]];
      e = e ^ (dec ? ks[15-rd] : ks[rd]);
      for (int b = 0; b < 8; b++) begin
        six = e[47-6*b -: 6];
        row = int'({six[5], six[0]});
        col = int'(six[4:1]);
        sout[31-4*b -: 4] = 4'(sb_t[b*64 + row*16 + col]);
      end
      for (int i = 0; i < 32; i++) f[31-i] = sout[32-p_t[i]];
      nl = r;
      r  = l ^ f;
      l  = nl;
    end
    t = {r, l};
    for (int i = 0; i < 64; i++) res[63-i] = t[64-fp_t[i]];
    return res;
  endfunction

  function automatic logic [63:0] tdes(input logic m, input logic [63:0] k1, input logic [63:0] k2,
                                       input logic [63:0] k3, input logic [63:0] x);
    if (!m) return des(k3, des(k2, des(k1, x, 1'b0), 1'b1), 1'b0);
    return des(k1, des(k2, des(k3, x, 1'b1), 1'b0), 1'b1);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, mode, start;
  logic [0:63] iv, key1, key2, key3, data_in;
  logic        valid_in [2];
  logic        ready_in [2];
  logic        spur     [2];
  logic        accept_out [2];
  logic        valid_out  [2];
  logic        err_out    [2];
  logic        cvalid_out [2];
  logic [0:63] data_out   [2];
  logic [0:63] cdata_out  [2];

  logic [63:0] sb_q [$];
  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        acc, vout, err, c_mode, c_vout, c_vin, busy;
    logic [0:63] dout, c_k1, c_k2, c_k3, c_dout, c_din;
    logic [63:0] res;
    int          cnt;

    tdes_cbc_ctrl #(.CBC_EN(g == 0 ? 1'b1 : 1'b0)) u_dut (
      .clk_i(clk), .reset_i(rst_n), .mode_i(mode), .start_i(start), .iv_i(iv),
      .key1_i(key1), .key2_i(key2), .key3_i(key3), .data_i(data_in),
      .valid_i(valid_in[g]), .accept_o(acc), .data_o(dout), .valid_o(vout),
      .ready_i(ready_in[g]), .core_mode_o(c_mode), .core_key1_o(c_k1),
      .core_key2_o(c_k2), .core_key3_o(c_k3), .core_data_o(c_dout),
      .core_valid_o(c_vout), .core_ready_i(!busy), .core_data_i(c_din),
      .core_valid_i(c_vin | spur[g]), .err_o(err));

    // Behavioural tdes core: one block, fixed latency, reset with the DUT.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        busy <= 1'b0; cnt <= 0; res <= '0; c_vin <= 1'b0; c_din <= '0;
      end else begin
        c_vin <= 1'b0;
        if (!busy && c_vout) begin
          busy <= 1'b1;
          cnt  <= CORE_LAT;
          res  <= tdes(c_mode, c_k1, c_k2, c_k3, c_dout);
        end else if (busy) begin
          if (cnt == 0) begin
            busy <= 1'b0; c_vin <= 1'b1; c_din <= res;
          end else begin
            cnt <= cnt - 1;
          end
        end
      end
    end

    assign accept_out[g] = acc;
    assign valid_out[g]  = vout;
    assign err_out[g]    = err;
    assign cvalid_out[g] = c_vout;
    assign data_out[g]   = dout;
    assign cdata_out[g]  = c_dout;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp_v);
    chk(tag, 64'(obs), 64'(exp_v));
  endtask

  task automatic send(input int idx, input logic [63:0] d, input logic m, input logic st,
                      input logic [63:0] exp_v);
    int n;
    @(negedge clk);
    data_in = d; mode = m; start = st; valid_in[idx] = 1'b1;
    n = 0;
    while (!accept_out[idx] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chkb("accept", accept_out[idx], 1'b1);
    @(negedge clk);
    valid_in[idx] = 1'b0; start = 1'b0;
    data_in = {$urandom(), $urandom()}; mode = ~m;
    chkb("issue_pulse", cvalid_out[idx], 1'b1);
    sb_q.push_back(exp_v);
  endtask

  task automatic recv(input int idx, input int hold);
    int n;
    logic [63:0] exp_v;
    n = 0;
    while (!valid_out[idx] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chkb("valid_wait", valid_out[idx], 1'b1);
    exp_v = sb_q.pop_front();
    chk("data", data_out[idx], exp_v);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_data", data_out[idx], exp_v);
      chkb("hold_valid", valid_out[idx], 1'b1);
      chkb("hold_accept", accept_out[idx], 1'b0);
      chkb("hold_issue", cvalid_out[idx], 1'b0);
    end
    ready_in[idx] = 1'b1;
    @(negedge clk);
    ready_in[idx] = 1'b0;
    chkb("valid_drop", valid_out[idx], 1'b0);
    chkb("accept_back", accept_out[idx], 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; start = 1'b0; iv = IV;
    key1 = KEY; key2 = KEY; key3 = KEY; data_in = '0;
    for (int i = 0; i < 2; i++) begin
      valid_in[i] = 1'b0; ready_in[i] = 1'b0; spur[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chkb("rst_valid", valid_out[0], 1'b0);
    chk("rst_data", data_out[0], 64'h0);
    chkb("rst_issue", cvalid_out[0], 1'b0);
    chk("rst_core_data", cdata_out[0], 64'h0);
    chkb("rst_err", err_out[0], 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chkb("rst_accept", accept_out[0], 1'b1);

    // CBC encrypt, second block under 10 cycles of backpressure
    send(0, 64'h4e6f772069732074, 1'b0, 1'b1, 64'he5c7cdde872bf27c); recv(0, 0);
    send(0, 64'h68652074696d6520, 1'b0, 1'b0, 64'h43e934008c389c0f); recv(0, 10);
    send(0, 64'h666f7220616c6c20, 1'b0, 1'b0, 64'h683788499a7c05f6); recv(0, 0);

    // CBC decrypt back to the plaintext
    send(0, 64'he5c7cdde872bf27c, 1'b1, 1'b1, 64'h4e6f772069732074); recv(0, 0);
    send(0, 64'h43e934008c389c0f, 1'b1, 1'b0, 64'h68652074696d6520); recv(0, 0);
    send(0, 64'h683788499a7c05f6, 1'b1, 1'b0, 64'h666f7220616c6c20); recv(0, 0);

    // ECB instance: start_i and iv_i must not matter
    iv = {$urandom(), $urandom()};
    send(1, 64'h4e6f772069732074, 1'b0, 1'b1, 64'h3fa40e8a984d4815); recv(1, 0);
    send(1, 64'h4e6f772069732074, 1'b0, 1'b0, 64'h3fa40e8a984d4815); recv(1, 0);
    send(1, 64'h3fa40e8a984d4815, 1'b1, 1'b1, 64'h4e6f772069732074); recv(1, 0);

    // Reset while waiting on the core, then replay vector 1
    iv = IV;
    send(0, 64'h4e6f772069732074, 1'b0, 1'b1, 64'he5c7cdde872bf27c);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chkb("midrst_valid", valid_out[0], 1'b0);
    chkb("midrst_issue", cvalid_out[0], 1'b0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    chkb("midrst_valid_hold", valid_out[0], 1'b0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chkb("post_rst_idle", valid_out[0], 1'b0);
    send(0, 64'h4e6f772069732074, 1'b0, 1'b1, 64'he5c7cdde872bf27c); recv(0, 0);
    send(0, 64'h68652074696d6520, 1'b0, 1'b0, 64'h43e934008c389c0f); recv(0, 0);
    send(0, 64'h666f7220616c6c20, 1'b0, 1'b0, 64'h683788499a7c05f6); recv(0, 0);
    chkb("no_err_yet", err_out[0], 1'b0);

    // Spurious core_valid_i in IDLE: sticky err_o, no output
    @(negedge clk);
    spur[0] = 1'b1;
    @(negedge clk);
    spur[0] = 1'b0;
    chkb("spur_err", err_out[0], 1'b1);
    chkb("spur_valid", valid_out[0], 1'b0);
    repeat (5) @(negedge clk);
    chkb("spur_valid_later", valid_out[0], 1'b0);
    send(0, 64'h4e6f772069732074, 1'b0, 1'b1, 64'he5c7cdde872bf27c); recv(0, 0);
    chkb("err_sticky", err_out[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chkb("err_cleared", err_out[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
